// File: rtl/chip8_alu_core.sv
// CHIP-8 style ALU: combinational op decode, one registered result stage.
// Flag word carries a single meaningful bit (bit 0).
module chip8_alu_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] alu_carry
);

  localparam int SW = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_OR    = 4'd1,
    OP_AND   = 4'd2,
    OP_XOR   = 4'd3,
    OP_ADD   = 4'd4,
    OP_MINUS = 4'd5,
    OP_LSH   = 4'd6,
    OP_RSH   = 4'd7,
    OP_EQ    = 4'd8,
    OP_GT    = 4'd9,
    OP_INC   = 4'd10
  } op_e;

  logic [WIDTH-1:0] res_d, res_q;
  logic             cy_d, cy_q;

  logic [WIDTH:0]   sum, diff, inc, lsh, rsh;
  logic [SW-1:0]    shamt;
  logic             sh_ok;
  logic             sh_big;

  assign sum    = {1'b0, input1} + {1'b0, input2};
  assign diff   = {1'b0, input1} - {1'b0, input2};
  assign inc    = {1'b0, input1} + (WIDTH+1)'(1);
  assign shamt  = input2[SW-1:0];
  assign sh_ok  = input2 <= WIDTH'(WIDTH);
  assign sh_big = input2 >= WIDTH'(WIDTH);
  // Extra bit on each side captures the last bit shifted out.
  assign lsh    = {1'b0, input1} << shamt;
  assign rsh    = {input1, 1'b0} >> shamt;

  always_comb begin
    res_d = '0;
    cy_d  = 1'b0;
    case (op_e'(sel))
      OP_OR:    res_d = input1 | input2;
      OP_AND:   res_d = input1 & input2;
      OP_XOR:   res_d = input1 ^ input2;
      OP_ADD: begin
        res_d = sum[WIDTH-1:0];
        cy_d  = sum[WIDTH];
      end
      OP_MINUS: begin
        res_d = diff[WIDTH-1:0];
        cy_d  = ~diff[WIDTH];
      end
      OP_LSH: begin
        res_d = sh_big ? '0 : lsh[WIDTH-1:0];
        cy_d  = sh_ok & lsh[WIDTH];
      end
      OP_RSH: begin
        res_d = sh_big ? '0 : rsh[WIDTH:1];
        cy_d  = sh_ok & rsh[0];
      end
      OP_EQ:    res_d = {{(WIDTH-1){1'b0}}, input1 == input2};
      OP_GT:    res_d = {{(WIDTH-1){1'b0}}, input1 > input2};
      OP_INC: begin
        res_d = inc[WIDTH-1:0];
        cy_d  = inc[WIDTH];
      end
      default: begin
        res_d = '0;
        cy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      cy_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      cy_q  <= cy_d;
    end
  end

  assign out       = res_q;
  assign alu_carry = {{(WIDTH-1){1'b0}}, cy_q};

endmodule

// File: tb/tb_chip8_alu_core.sv
// Scoreboard bench for chip8_alu_core: directed vectors plus random ops
// against an arithmetic reference model.
module tb_chip8_alu_core;

  logic        clk;
  logic        reset;
  logic [15:0] input1;
  logic [15:0] input2;
  logic [3:0]  sel;
  logic [15:0] out;
  logic [15:0] alu_carry;

  int tests;
  int fails;

  typedef struct {
    int          op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic [15:0] ec;
  } exp_t;

  exp_t q[$];

  chip8_alu_core #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .input1    (input1),
    .input2    (input2),
    .sel       (sel),
    .out       (out),
    .alu_carry (alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(int a, int b, int s);
    int r;
    int c;
    r = 0;
    c = 0;
    case (s)
      1: r = a | b;
      2: r = a & b;
      3: r = a ^ b;
      4: begin
        r = a + b;
        c = (r > 65535) ? 1 : 0;
        r = r % 65536;
      end
      5: begin
        c = (a >= b) ? 1 : 0;
        r = (a - b + 65536) % 65536;
      end
      6: begin
        if (b >= 1 && b <= 16) c = (a >> (16 - b)) & 1;
        r = (b >= 16) ? 0 : (a * (1 << b)) % 65536;
      end
      7: begin
        if (b >= 1 && b <= 16) c = (a >> (b - 1)) & 1;
        r = (b >= 16) ? 0 : a / (1 << b);
      end
      8: r = (a == b) ? 1 : 0;
      9: r = (a > b) ? 1 : 0;
      10: begin
        r = (a + 1) % 65536;
        c = (a == 65535) ? 1 : 0;
      end
      default: begin
        r = 0;
        c = 0;
      end
    endcase
    return {c[0], r[15:0]};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive(int s, logic [15:0] a, logic [15:0] b);
    exp_t e;
    logic [16:0] m;
    @(negedge clk);
    input1 = a;
    input2 = b;
    sel    = 4'(s);
    m      = model(int'(a), int'(b), s);
    e.op = s;
    e.a  = a;
    e.b  = b;
    e.eo = m[15:0];
    e.ec = {15'd0, m[16]};
    q.push_back(e);
  endtask

  // Monitor: one result per clock once reset is released.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (out !== e.eo || alu_carry !== e.ec) begin
          fails++;
          $display("FAIL op%0d a=%h b=%h: got out=%h cy=%h, required out=%h cy=%h",
                   e.op, e.a, e.b, out, alu_carry, e.eo, e.ec);
        end
      end
    end
  end

  initial begin
    logic [15:0] acc;
    int s;
    logic [15:0] a, b;
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    input1 = 16'h1234;
    input2 = 16'h0001;
    sel    = 4'd4;
    #1;
    check("reset_out", out, 16'h0000);
    check("reset_cy", alu_carry, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_out", out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    drive(1, 16'hA0F0, 16'h50F0);
    drive(2, 16'h0AFF, 16'h05FF);
    drive(3, 16'hF5A0, 16'hFA50);
    drive(4, 16'h7FFF, 16'h0001);
    drive(4, 16'hC000, 16'hC000);
    drive(4, 16'h4E88, 16'h4309);
    drive(5, 16'hC3C3, 16'hC3C3);
    drive(5, 16'hE0A5, 16'h7003);
    drive(5, 16'h0001, 16'h0002);
    drive(6, 16'h4F00, 16'd4);
    drive(7, 16'h0031, 16'd2);
    drive(7, 16'h0031, 16'd1);
    drive(6, 16'hFFFF, 16'd16);
    drive(7, 16'hFFFF, 16'd16);
    drive(6, 16'hFFFF, 16'd17);
    drive(7, 16'h8001, 16'd40);
    drive(6, 16'h8001, 16'd0);
    drive(8, 16'h0832, 16'h0832);
    drive(8, 16'h0031, 16'h0002);
    drive(9, 16'h8832, 16'h0832);
    drive(9, 16'h0832, 16'h8832);
    drive(10, 16'hFFFF, 16'h1234);
    drive(0, 16'hFFFF, 16'hFFFF);
    drive(13, 16'hFFFF, 16'h0001);

    acc = 16'h0008;
    for (int i = 0; i < 16; i++) begin
      drive(10, acc, 16'h0000);
      acc = acc + 16'd1;
    end
    @(posedge clk);
    #1;
    check("inc_chain_out", out, 16'h0018);

    // Pending INC issued, then reset lands before the capturing edge.
    drive(10, 16'h0041, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_out", out, 16'h0000);
    check("mid_reset_cy", alu_carry, 16'h0000);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_discard_out", out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      s = $urandom_range(0, 15);
      a = 16'($urandom);
      b = 16'($urandom);
      if ((s == 6 || s == 7) && ($urandom_range(0, 3) != 0))
        b = 16'($urandom_range(0, 20));
      if ($urandom_range(0, 9) == 0) b = a;
      if ($urandom_range(0, 19) == 0) a = 16'hFFFF;
      drive(s, a, b);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
